// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the CLB configuration loader.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Width of the config word delivered to every CLB.
  localparam int CFG_W = 23;

  // Field positions inside the config word.
  localparam int OUT_SEL_MSB = 22;
  localparam int OUT_SEL_LSB = 19;
  localparam int O_MUX_BIT   = 18;
  localparam int FF_EN_MSB   = 17;
  localparam int FF_EN_LSB   = 16;
  localparam int LUT_MSB     = 15;
  localparam int LUT_LSB     = 0;

endpackage

// File: rtl/cfg_frame_shifter.sv
// Serial frame receiver: collects one MSB-first frame, counts its bits and
// checks even parity over the whole frame as the last bit arrives.
module cfg_frame_shifter #(
  parameter int FRAME_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               ser_data,
  output logic               frame_done,
  output logic               parity_ok,
  output logic [FRAME_W-2:0] cfg_next
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  // Only the newest FRAME_W-1 bits are kept: together with the incoming bit
  // they form the complete frame on the accepting cycle.
  logic [FRAME_W-2:0] sr;
  logic [CNT_W-1:0]   cnt;

  // Frame is complete when the last bit is being accepted this cycle.
  always_comb begin
    frame_done = shift_en && (cnt == CNT_LAST);
    parity_ok  = ~(^{sr, ser_data});
    cfg_next   = sr;
  end

  // Shift register and bit counter; counter wraps to 0 at the end of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[FRAME_W-3:0], ser_data};
      cnt <= frame_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// CLB configuration loader: receives N_CLB parity-protected serial frames and
// writes each config word to its CLB with a one-hot strobe.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_SHIFT | receiving frame clb_idx, ser_ready high
// ST_WRITE | one-cycle write strobe to CLB clb_idx
// ST_DONE  | all frames written, done high until start
// ST_ERR   | parity failure, load aborted, err high until start
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int N_CLB   = 4,
  parameter int FRAME_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     ser_valid,
  input  logic                     ser_data,
  output logic                     ser_ready,
  output logic [CFG_W-1:0]         bits,
  output logic [N_CLB-1:0]         wr_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(N_CLB)-1:0] clb_idx
);

  localparam int IDX_W = $clog2(N_CLB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLB - 1);

  state_t             state, state_nxt;
  logic               load_start;
  logic               shift_en;
  logic               frame_done;
  logic               parity_ok;
  logic [FRAME_W-2:0] cfg_next;

  assign load_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign shift_en   = ser_valid && ser_ready;

  cfg_frame_shifter #(
    .FRAME_W (FRAME_W)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_start),
    .shift_en   (shift_en),
    .ser_data   (ser_data),
    .frame_done (frame_done),
    .parity_ok  (parity_ok),
    .cfg_next   (cfg_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    ser_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    wr_en     = '0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        done = (state == ST_DONE);
        err  = (state == ST_ERR);
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_ready = 1'b1;
        busy      = 1'b1;
        if (frame_done) state_nxt = parity_ok ? ST_WRITE : ST_ERR;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        wr_en     = N_CLB'(1) << clb_idx;
        state_nxt = (clb_idx == IDX_LAST) ? ST_DONE : ST_SHIFT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // CLB index: cleared at load start, advanced after each non-final write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      clb_idx <= '0;
    else if (load_start)                             clb_idx <= '0;
    else if (state == ST_WRITE && clb_idx != IDX_LAST) clb_idx <= clb_idx + 1'b1;
  end

  // Config word captured on the last-bit cycle so it is valid during WRITE
  // and holds until the next good frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (frame_done && parity_ok) begin
      bits[OUT_SEL_MSB:OUT_SEL_LSB] <= cfg_next[OUT_SEL_MSB:OUT_SEL_LSB];
      bits[O_MUX_BIT]               <= cfg_next[O_MUX_BIT];
      bits[FF_EN_MSB:FF_EN_LSB]     <= cfg_next[FF_EN_MSB:FF_EN_LSB];
      bits[LUT_MSB:LUT_LSB]         <= cfg_next[LUT_MSB:LUT_LSB];
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed testbench for cfg_loader with N_CLB=4, FRAME_W=24.
module tb_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ser_valid = 1'b0;
  logic        ser_data = 1'b0;
  logic        ser_ready;
  logic [22:0] bits;
  logic [3:0]  wr_en;
  logic        busy, done, err;
  logic [1:0]  clb_idx;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;
  int c0 = 0;

  logic [22:0] cfg_tab [4];
  logic [3:0]  pulse_wr[$];
  logic [22:0] pulse_bits[$];
  int          pulse_cyc[$];
  int          acc_cyc[$];

  cfg_loader #(.N_CLB(4), .FRAME_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_ready (ser_ready),
    .bits      (bits),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .clb_idx   (clb_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every cycle with any write strobe active.
  always @(negedge clk) begin
    if (wr_en !== 4'b0000) begin
      pulse_wr.push_back(wr_en);
      pulse_bits.push_back(bits);
      pulse_cyc.push_back(cyc);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    pulse_wr.delete();
    pulse_bits.delete();
    pulse_cyc.delete();
  endtask

  // Called at a negedge; returns at the negedge right after start is sampled.
  task automatic do_start();
    start = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams n_bits of the frame table MSB first. bad_frame gets its parity
  // bit inverted. rnd randomises ser_valid; start is held high while fewer
  // than keep_start bits have been accepted.
  task automatic send_stream(input int n_bits, input int bad_frame, input bit rnd,
                             input int keep_start);
    int idx = 0;
    int budget = 0;
    int f;
    logic [23:0] fr;
    logic v;
    acc_cyc.delete();
    while (idx < n_bits && err !== 1'b1 && budget < 3000) begin
      f = (idx / 24) % 4;
      fr = {cfg_tab[f], (^cfg_tab[f]) ^ (f == bad_frame)};
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ser_valid = v;
      ser_data = fr[23 - (idx % 24)];
      start = (idx < keep_start);
      if (v && ser_ready === 1'b1) begin
        if (idx % 24 == 23) acc_cyc.push_back(cyc + 1);
        idx++;
      end
      budget++;
      @(negedge clk);
    end
    ser_valid = 1'b0;
    ser_data = 1'b0;
    start = 1'b0;
    vec_cnt++;
    if (budget >= 3000) begin
      miss_cnt++;
      $display("FAIL send_timeout: accepted %0d bits, wanted %0d", idx, n_bits);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({ser_ready, busy, done, err} !== 4'b0000) begin
      miss_cnt++;
      $display("FAIL reset_flags: got %b want 0000", {ser_ready, busy, done, err});
    end
    vec_cnt++;
    if (wr_en !== 4'b0000 || bits !== 23'h0 || clb_idx !== 2'd0) begin
      miss_cnt++;
      $display("FAIL reset_data: wr_en=%b bits=%h idx=%0d want 0", wr_en, bits, clb_idx);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (busy !== 1'b0 || ser_ready !== 1'b0 || pulse_wr.size() != 0) begin
      miss_cnt++;
      $display("FAIL idle_no_start: busy=%b ready=%b pulses=%0d want 0 0 0",
               busy, ser_ready, pulse_wr.size());
    end
  endtask

  task automatic test_clean_load();
    clear_log();
    do_start();
    vec_cnt++;
    if (busy !== 1'b1 || ser_ready !== 1'b1 || clb_idx !== 2'd0) begin
      miss_cnt++;
      $display("FAIL clean_shift_entry: busy=%b ready=%b idx=%0d want 1 1 0",
               busy, ser_ready, clb_idx);
    end
    send_stream(96, -1, 1'b0, 0);
    vec_cnt++;
    if (done !== 1'b0 || cyc - c0 !== 99) begin
      miss_cnt++;
      $display("FAIL clean_pre_done: done=%b rel=%0d want 0 99", done, cyc - c0);
    end
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || cyc - c0 !== 100) begin
      miss_cnt++;
      $display("FAIL clean_done: done=%b busy=%b rel=%0d want 1 0 100", done, busy, cyc - c0);
    end
    vec_cnt++;
    if (pulse_wr.size() != 4) begin
      miss_cnt++;
      $display("FAIL clean_pulse_count: got %0d want 4", pulse_wr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vec_cnt++;
        if (pulse_wr[k] !== 4'(1 << k) || pulse_bits[k] !== cfg_tab[k] ||
            pulse_cyc[k] - c0 != 24 + 25 * k) begin
          miss_cnt++;
          $display("FAIL clean_pulse%0d: wr=%b bits=%h rel=%0d want %b %h %0d", k,
                   pulse_wr[k], pulse_bits[k], pulse_cyc[k] - c0, 4'(1 << k),
                   cfg_tab[k], 24 + 25 * k);
        end
      end
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (done !== 1'b1 || bits !== cfg_tab[3]) begin
      miss_cnt++;
      $display("FAIL done_hold: done=%b bits=%h want 1 %h", done, bits, cfg_tab[3]);
    end
  endtask

  task automatic test_parity_err();
    clear_log();
    do_start();
    vec_cnt++;
    if (done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL err_done_cleared: done=%b want 0", done);
    end
    send_stream(96, 2, 1'b0, 0);
    vec_cnt++;
    if ({err, busy, ser_ready, done} !== 4'b1000) begin
      miss_cnt++;
      $display("FAIL err_flags: err/busy/ready/done=%b want 1000", {err, busy, ser_ready, done});
    end
    ser_valid = 1'b1;
    repeat (5) @(negedge clk);
    ser_valid = 1'b0;
    vec_cnt++;
    if (err !== 1'b1 || pulse_wr.size() != 2) begin
      miss_cnt++;
      $display("FAIL err_hold: err=%b pulses=%0d want 1 2", err, pulse_wr.size());
    end else begin
      vec_cnt++;
      if (pulse_wr[0] !== 4'b0001 || pulse_wr[1] !== 4'b0010 ||
          pulse_bits[0] !== cfg_tab[0] || pulse_bits[1] !== cfg_tab[1]) begin
        miss_cnt++;
        $display("FAIL err_pulses: %b %b bits %h %h want 0001 0010 %h %h",
                 pulse_wr[0], pulse_wr[1], pulse_bits[0], pulse_bits[1], cfg_tab[0], cfg_tab[1]);
      end
    end
  endtask

  task automatic test_random_valid();
    clear_log();
    do_start();
    vec_cnt++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miss_cnt++;
      $display("FAIL rnd_err_cleared: err=%b busy=%b want 0 1", err, busy);
    end
    send_stream(96, -1, 1'b1, 0);
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b1) begin
      miss_cnt++;
      $display("FAIL rnd_done: done=%b want 1", done);
    end
    vec_cnt++;
    if (pulse_wr.size() != 4 || acc_cyc.size() != 4) begin
      miss_cnt++;
      $display("FAIL rnd_pulse_count: pulses=%0d frames=%0d want 4 4",
               pulse_wr.size(), acc_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vec_cnt++;
        if (pulse_wr[k] !== 4'(1 << k) || pulse_bits[k] !== cfg_tab[k] ||
            pulse_cyc[k] != acc_cyc[k]) begin
          miss_cnt++;
          $display("FAIL rnd_pulse%0d: wr=%b bits=%h cyc=%0d want %b %h %0d", k,
                   pulse_wr[k], pulse_bits[k], pulse_cyc[k], 4'(1 << k), cfg_tab[k], acc_cyc[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    do_start();
    send_stream(34, -1, 1'b0, 0);
    vec_cnt++;
    if (busy !== 1'b1 || clb_idx !== 2'd1 || pulse_wr.size() != 1) begin
      miss_cnt++;
      $display("FAIL mid_state: busy=%b idx=%0d pulses=%0d want 1 1 1",
               busy, clb_idx, pulse_wr.size());
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({ser_ready, busy, done, err, wr_en, bits, clb_idx} !== 33'h0) begin
      miss_cnt++;
      $display("FAIL async_reset: ready=%b busy=%b done=%b err=%b wr=%b bits=%h idx=%0d want all 0",
               ser_ready, busy, done, err, wr_en, bits, clb_idx);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (pulse_wr.size() != 1 || busy !== 1'b0 || ser_ready !== 1'b0) begin
      miss_cnt++;
      $display("FAIL post_reset_idle: pulses=%0d busy=%b ready=%b want 1 0 0",
               pulse_wr.size(), busy, ser_ready);
    end
    clear_log();
    do_start();
    send_stream(96, -1, 1'b0, 0);
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b1 || pulse_wr.size() != 4) begin
      miss_cnt++;
      $display("FAIL reload_done: done=%b pulses=%0d want 1 4", done, pulse_wr.size());
    end else begin
      vec_cnt++;
      if (pulse_wr[0] !== 4'b0001 || pulse_bits[0] !== cfg_tab[0] || pulse_cyc[0] - c0 != 24) begin
        miss_cnt++;
        $display("FAIL reload_first: wr=%b bits=%h rel=%0d want 0001 %h 24",
                 pulse_wr[0], pulse_bits[0], pulse_cyc[0] - c0, cfg_tab[0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    clear_log();
    do_start();
    send_stream(96, -1, 1'b0, 60);
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b1 || cyc - c0 !== 100) begin
      miss_cnt++;
      $display("FAIL hold_start_done: done=%b rel=%0d want 1 100", done, cyc - c0);
    end
    vec_cnt++;
    if (pulse_wr.size() != 4) begin
      miss_cnt++;
      $display("FAIL hold_start_pulses: got %0d want 4", pulse_wr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vec_cnt++;
        if (pulse_wr[k] !== 4'(1 << k) || pulse_cyc[k] - c0 != 24 + 25 * k) begin
          miss_cnt++;
          $display("FAIL hold_start_pulse%0d: wr=%b rel=%0d want %b %0d", k,
                   pulse_wr[k], pulse_cyc[k] - c0, 4'(1 << k), 24 + 25 * k);
        end
      end
    end
    vec_cnt++;
    if (clb_idx !== 2'd3) begin
      miss_cnt++;
      $display("FAIL done_idx: got %0d want 3", clb_idx);
    end
    clear_log();
    do_start();
    vec_cnt++;
    if (done !== 1'b0 || busy !== 1'b1 || clb_idx !== 2'd0 || ser_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL restart_from_done: done=%b busy=%b idx=%0d ready=%b want 0 1 0 1",
               done, busy, clb_idx, ser_ready);
    end
    send_stream(96, -1, 1'b0, 0);
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b1 || pulse_wr.size() != 4) begin
      miss_cnt++;
      $display("FAIL restart_done: done=%b pulses=%0d want 1 4", done, pulse_wr.size());
    end else begin
      vec_cnt++;
      if (pulse_wr[0] !== 4'b0001 || pulse_bits[0] !== cfg_tab[0]) begin
        miss_cnt++;
        $display("FAIL restart_first: wr=%b bits=%h want 0001 %h",
                 pulse_wr[0], pulse_bits[0], cfg_tab[0]);
      end
    end
  endtask

  initial begin
    cfg_tab[0] = 23'h7FFFFF;
    cfg_tab[1] = 23'h000000;
    cfg_tab[2] = 23'h5A5A5A;
    cfg_tab[3] = 23'h012345;
    test_reset();
    test_clean_load();
    test_parity_err();
    test_random_valid();
    test_reset_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter N_CLB, default 4, number of CLBs configured per load (2..16).
REQ-002 Parameter FRAME_W, default 24, serial frame length: 23 config bits + 1 even-parity bit.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level-sampled request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-006 ser_valid  in  1  serial bit present on ser_data.
REQ-007 ser_data  in  1  serial config bit, MSB first.
REQ-008 ser_ready  out  1  loader accepts a bit this cycle.
REQ-009 bits  out  23  config word to all CLBs: [22:19] out_sel, [18] LUT/DFF mux, [17:16] DFF-enable select, [15:0] LUT.
REQ-010 wr_en  out  N_CLB  one-hot write strobe, bit k loads CLB k.
REQ-011 busy  out  1  load in progress.
REQ-012 done  out  1  all N_CLB frames written without error.
REQ-013 err  out  1  parity failure aborted the load.
REQ-014 clb_idx  out  $clog2(N_CLB)  index of the frame being received or written.

Function
REQ-015 FSM states IDLE, SHIFT, WRITE, DONE, ERR; reset state IDLE.
REQ-016 IDLE/DONE/ERR + start=1 -> SHIFT next cycle; clb_idx, bit counter and shift register cleared; done and err cleared.
REQ-017 start is ignored in SHIFT and WRITE.
REQ-018 ser_ready=1 only in SHIFT; a bit is accepted when ser_valid && ser_ready; shift register shifts left, ser_data enters the LSB.
REQ-019 ser_valid low in SHIFT stalls; no counter or state change.
REQ-020 Acceptance of the FRAME_W-th bit of a frame -> WRITE next cycle if the XOR of all 24 bits is 0, else ERR.
REQ-021 WRITE lasts exactly one cycle: bits = frame[23:1] (registered), wr_en[clb_idx]=1, all other wr_en bits 0, ser_ready=0.
REQ-022 bits is valid in the same cycle wr_en is high and holds its value until the next WRITE.
REQ-023 WRITE with clb_idx==N_CLB-1 -> DONE; otherwise clb_idx increments and the next state is SHIFT.
REQ-024 Latency: the WRITE cycle immediately follows the cycle that accepts the last bit of a frame; minimum load time N_CLB*(FRAME_W+1) cycles after start is sampled.
REQ-025 DONE: done=1, busy=0, held until start or reset.
REQ-026 ERR: err=1, busy=0, no further wr_en; frames already written are not rolled back; held until start or reset.
REQ-027 busy=1 exactly in SHIFT and WRITE.
REQ-028 wr_en is never high outside WRITE and never has more than one bit set.
REQ-029 A parity error on frame k leaves CLBs 0..k-1 written and CLBs k..N_CLB-1 untouched.

Reset
REQ-030 rst_n low asynchronously forces state IDLE and sets bits, wr_en, clb_idx, busy, done, err, ser_ready, the shift register and the bit counter to 0.
REQ-031 Reset during SHIFT or WRITE aborts the load with no wr_en pulse after assertion; after release the loader waits in IDLE for start.

Structure
REQ-032 A shared package holds the FSM state enum, the CFG_W=23 constant and the bits field positions (OUT_SEL, O_MUX, FF_EN, LUT).
REQ-033 One sub-module, cfg_frame_shifter, holds the shift register, bit counter and parity check and outputs frame_done and parity_ok; cfg_loader holds the FSM, index counter and wr_en decode.

Verification
REQ-034 N_CLB=4, start, then 4 clean frames with values 23'h7FFFFF, 23'h000000, 23'h5A5A5A, 23'h12345 and ser_valid held high -> wr_en pulses 0001, 0010, 0100, 1000, each one cycle and 25 cycles apart, with bits matching each frame; done=1 in cycle 100 after start is sampled.
REQ-035 Frame 2 sent with its parity bit flipped -> wr_en 0001 and 0010 pulse only, then err=1, busy=0, ser_ready=0, and no wr_en 0100.
REQ-036 ser_valid toggled randomly at 50% during a 4-frame load -> same wr_en and bits sequence as REQ-034; no pulse until the 24th bit of each frame is accepted.
REQ-037 rst_n pulled low while 10 bits of frame 1 are loaded -> all outputs 0 at once; after release and a new start, frame 0 goes to wr_en 0001.
REQ-038 start held high during SHIFT, and start pulsed in DONE -> ignored in SHIFT; in DONE, done clears and a new load begins at clb_idx=0.
